// File: rtl/dmem_arb_if.sv
// Bus bundle for dmem_arb: CPU request port, DMA request port and the shared memory port.
// slave = arbiter view, master = view of the surrounding CPU/DMA/memory environment.
interface dmem_arb_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [1:0]  cpu_be_op;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        cpu_err;
    logic        cpu_stall;

    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [31:0] dma_rdata;
    logic        dma_ack;

    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport slave (
        input  cpu_req, cpu_we, cpu_be_op, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_err, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output cpu_req, cpu_we, cpu_be_op, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_err, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/dmem_arb.sv
// Data-memory arbiter sharing one memory port between the CPU M-stage and a DMA engine.
// Optional round-robin tie-breaking is enabled by defining MEM_ARB_RR_EN (default: CPU wins ties).
module dmem_arb (
    input  logic      clk,
    input  logic      reset,
    dmem_arb_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CPU_ACC  = 3'd1,
        DMA_ACC  = 3'd2,
        CPU_DONE = 3'd3,
        DMA_DONE = 3'd4
    } state_t;

    function automatic logic [3:0] be_of(input logic [1:0] op, input logic [1:0] off);
        logic [3:0] be;
        case (op)
            2'd1:    be = 4'b0001 << off;
            2'd2:    be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lanes_of(input logic [1:0] op, input logic [31:0] wdata);
        logic [31:0] d;
        case (op)
            2'd1:    d = {4{wdata[7:0]}};
            2'd2:    d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    function automatic logic misaligned(input logic [1:0] op, input logic [1:0] off);
        logic m;
        case (op)
            2'd0, 2'd3: m = (off != 2'b00);
            2'd2:       m = off[0];
            default:    m = 1'b0;
        endcase
        return m;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] dma_rdata_q, dma_rdata_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        cpu_err_q, cpu_err_d;
    logic        dma_ack_q, dma_ack_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic        pick_cpu_s;
    logic        pick_dma_s;

`ifdef MEM_ARB_RR_EN
    logic        last_dma_q, last_dma_d;

    // On a tie the CPU wins only if the DMA was served last.
    assign pick_cpu_s = bus.cpu_req & (~bus.dma_req | last_dma_q);

    // Last-winner flag follows every grant made from IDLE.
    always_comb begin
        last_dma_d = last_dma_q;
        if (state_q == IDLE) begin
            if (pick_cpu_s) begin
                last_dma_d = 1'b0;
            end else if (pick_dma_s) begin
                last_dma_d = 1'b1;
            end else begin
                last_dma_d = last_dma_q;
            end
        end else begin
            last_dma_d = last_dma_q;
        end
    end

    // Last-winner register; starts as DMA so the first tie goes to the CPU.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_dma_q <= 1'b1;
        end else begin
            last_dma_q <= last_dma_d;
        end
    end
`else
    assign pick_cpu_s = bus.cpu_req;
`endif

    assign pick_dma_s = bus.dma_req & ~pick_cpu_s;

    // Next-state, latched request fields and registered output values.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        cpu_ack_d   = 1'b0;
        cpu_err_d   = 1'b0;
        dma_ack_d   = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_cpu_s) begin
                    if (misaligned(bus.cpu_be_op, bus.cpu_addr[1:0])) begin
                        // Misaligned CPU accesses never reach memory.
                        state_d   = CPU_DONE;
                        cpu_ack_d = 1'b1;
                        cpu_err_d = 1'b1;
                    end else begin
                        state_d  = CPU_ACC;
                        addr_d   = bus.cpu_addr & 32'hFFFF_FFFC;
                        we_d     = bus.cpu_we;
                        be_d     = be_of(bus.cpu_be_op, bus.cpu_addr[1:0]);
                        wdata_d  = lanes_of(bus.cpu_be_op, bus.cpu_wdata);
                        mem_en_d = 1'b1;
                        mem_we_d = bus.cpu_we;
                    end
                end else if (pick_dma_s) begin
                    state_d  = DMA_ACC;
                    addr_d   = bus.dma_addr & 32'hFFFF_FFFC;
                    we_d     = bus.dma_we;
                    be_d     = 4'b1111;
                    wdata_d  = bus.dma_wdata;
                    mem_en_d = 1'b1;
                    mem_we_d = bus.dma_we;
                end else begin
                    state_d = IDLE;
                end
            end
            CPU_ACC: begin
                if (bus.mem_ready) begin
                    if (!we_q) begin
                        cpu_rdata_d = bus.mem_rdata;
                    end else begin
                        cpu_rdata_d = cpu_rdata_q;
                    end
                    state_d   = CPU_DONE;
                    cpu_ack_d = 1'b1;
                end else begin
                    mem_en_d = 1'b1;
                    mem_we_d = we_q;
                end
            end
            DMA_ACC: begin
                if (bus.mem_ready) begin
                    if (!we_q) begin
                        dma_rdata_d = bus.mem_rdata;
                    end else begin
                        dma_rdata_d = dma_rdata_q;
                    end
                    state_d   = DMA_DONE;
                    dma_ack_d = 1'b1;
                end else begin
                    mem_en_d = 1'b1;
                    mem_we_d = we_q;
                end
            end
            CPU_DONE: state_d = IDLE;
            DMA_DONE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State and output registers; reset clears everything, aborting any access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= 32'h0000_0000;
            we_q        <= 1'b0;
            be_q        <= 4'b0000;
            wdata_q     <= 32'h0000_0000;
            cpu_rdata_q <= 32'h0000_0000;
            dma_rdata_q <= 32'h0000_0000;
            cpu_ack_q   <= 1'b0;
            cpu_err_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_err_q   <= cpu_err_d;
            dma_ack_q   <= dma_ack_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_err   = cpu_err_q;
    assign bus.dma_rdata = dma_rdata_q;
    assign bus.dma_ack   = dma_ack_q;
    // Freeze the pipeline for as long as a CPU request is outstanding.
    assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_dmem_arb.sv
// Self-checking bench for dmem_arb: vector table with a queue scoreboard, plus tie and reset sequences.
module tb_dmem_arb;

    typedef struct {
        logic        is_dma;
        logic        we;
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        logic        exp_en;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        int          exp_lat;
        logic        exp_err;
    } vec_t;

    logic        clk;
    logic        reset;
    int          checks;
    int          errors;
    vec_t        vecs[13];
    vec_t        exp_q[$];
    logic [31:0] model_cpu_rdata;
    logic [31:0] model_dma_rdata;

    dmem_arb_if bus();

    dmem_arb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic is_dma, input logic we, input logic [1:0] op,
                                input logic [31:0] addr, input logic [31:0] wdata, input int waits,
                                input logic [31:0] rdata, input logic exp_en, input logic [3:0] exp_be,
                                input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                                input int exp_lat, input logic exp_err);
        vec_t v;
        v.is_dma = is_dma; v.we = we; v.op = op; v.addr = addr; v.wdata = wdata;
        v.waits = waits; v.rdata = rdata; v.exp_en = exp_en; v.exp_be = exp_be;
        v.exp_addr = exp_addr; v.exp_wdata = exp_wdata; v.exp_lat = exp_lat; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero();
        chk("rst_mem_en", 32'(bus.mem_en), 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        chk("rst_mem_be", 32'(bus.mem_be), 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_cpu_ack", 32'(bus.cpu_ack), 32'h0);
        chk("rst_cpu_err", 32'(bus.cpu_err), 32'h0);
        chk("rst_dma_ack", 32'(bus.dma_ack), 32'h0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
        chk("rst_dma_rdata", bus.dma_rdata, 32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        model_cpu_rdata = 32'h0;
        model_dma_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero();
        reset = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        int   cnt;
        int   waits;
        bit   done;
        bit   seen_en;
        logic ack;
        @(posedge clk); #1;
        if (v.is_dma) begin
            bus.dma_req = 1'b1; bus.dma_we = v.we; bus.dma_addr = v.addr; bus.dma_wdata = v.wdata;
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_we = v.we; bus.cpu_be_op = v.op;
            bus.cpu_addr = v.addr; bus.cpu_wdata = v.wdata;
        end
        exp_q.push_back(v);
        waits = v.waits; done = 1'b0; seen_en = 1'b0; cnt = 0;
        while (!done && cnt < 40) begin
            @(negedge clk);
            if (bus.mem_en) begin
                if (!seen_en) begin
                    seen_en = 1'b1;
                    chk("mem_be", 32'(bus.mem_be), 32'(v.exp_be));
                    chk("mem_addr", bus.mem_addr, v.exp_addr);
                    chk("mem_we", 32'(bus.mem_we), 32'(v.we));
                    if (v.we) chk("mem_wdata", bus.mem_wdata, v.exp_wdata);
                end
                if (waits == 0) begin
                    bus.mem_ready = 1'b1; bus.mem_rdata = v.rdata;
                end else begin
                    bus.mem_ready = 1'b0; waits--;
                end
            end else begin
                bus.mem_ready = 1'b0;
            end
            ack = v.is_dma ? bus.dma_ack : bus.cpu_ack;
            if (ack) begin
                e = exp_q.pop_front();
                chk("ack_latency", 32'(cnt), 32'(e.exp_lat));
                if (!e.is_dma) begin
                    chk("cpu_err", 32'(bus.cpu_err), 32'(e.exp_err));
                    chk("stall_at_ack", 32'(bus.cpu_stall), 32'h0);
                end
                done = 1'b1;
            end else if (!v.is_dma) begin
                chk("stall_wait", 32'(bus.cpu_stall), 32'h1);
                chk("err_without_ack", 32'(bus.cpu_err), 32'h0);
            end
            cnt++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL ack_timeout: got no ack within %0d cycles, required ack", cnt);
        end
        chk("mem_en_seen", 32'(seen_en), 32'(v.exp_en));
        bus.cpu_req = 1'b0; bus.dma_req = 1'b0; bus.mem_ready = 1'b0;
        if (done && v.exp_en && !v.we) begin
            if (v.is_dma) model_dma_rdata = v.rdata;
            else          model_cpu_rdata = v.rdata;
        end
        @(posedge clk); #1;
        chk("cpu_rdata", bus.cpu_rdata, model_cpu_rdata);
        chk("dma_rdata", bus.dma_rdata, model_dma_rdata);
    endtask

    task automatic serve_one(output logic [31:0] addr_seen, output logic who_cpu, output bit ok);
        int cnt;
        addr_seen = 32'h0; who_cpu = 1'b0; ok = 1'b0; cnt = 0;
        while (!ok && cnt < 20) begin
            @(negedge clk);
            if (bus.mem_en) begin
                addr_seen = bus.mem_addr; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0;
            end else begin
                bus.mem_ready = 1'b0;
            end
            if (bus.cpu_ack || bus.dma_ack) begin
                ok = 1'b1; who_cpu = bus.cpu_ack;
            end
            cnt++;
        end
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] a1;
        logic [31:0] a2;
        logic        c1;
        logic        c2;
        bit          ok1;
        bit          ok2;
        bit          seen;
        checks = 0; errors = 0;
        model_cpu_rdata = 32'h0; model_dma_rdata = 32'h0;
        reset = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_be_op = 2'd0;
        bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = 32'h0; bus.dma_wdata = 32'h0;
        bus.mem_rdata = 32'h0; bus.mem_ready = 1'b0;

        //          dma   we    op    addr          wdata         wt rdata         en    be       maddr         mwdata        lat err
        vecs[0]  = mk(1'b0, 1'b1, 2'd0, 32'h0000_0010, 32'hAABB_CCDD, 0, 32'h0,         1'b1, 4'b1111, 32'h0000_0010, 32'hAABB_CCDD, 2, 1'b0);
        vecs[1]  = mk(1'b0, 1'b1, 2'd1, 32'h0000_0013, 32'h0000_00EE, 0, 32'h0,         1'b1, 4'b1000, 32'h0000_0010, 32'hEEEE_EEEE, 2, 1'b0);
        vecs[2]  = mk(1'b0, 1'b0, 2'd2, 32'h0000_0021, 32'h0,         0, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0,         1, 1'b1);
        vecs[3]  = mk(1'b1, 1'b0, 2'd0, 32'h0000_0040, 32'h0,         3, 32'h1234_5678, 1'b1, 4'b1111, 32'h0000_0040, 32'h0,         5, 1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 2'd0, 32'h0000_0104, 32'h0,         1, 32'hCAFE_F00D, 1'b1, 4'b1111, 32'h0000_0104, 32'h0,         3, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, 2'd2, 32'h0000_0022, 32'h1234_BEEF, 0, 32'h0,         1'b1, 4'b1100, 32'h0000_0020, 32'hBEEF_BEEF, 2, 1'b0);
        vecs[6]  = mk(1'b0, 1'b1, 2'd1, 32'h0000_0031, 32'h0000_005A, 0, 32'h0,         1'b1, 4'b0010, 32'h0000_0030, 32'h5A5A_5A5A, 2, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 2'd0, 32'h0000_0007, 32'h0,         0, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0,         1, 1'b1);
        vecs[8]  = mk(1'b1, 1'b1, 2'd0, 32'h0000_0083, 32'h1122_3344, 0, 32'h0,         1'b1, 4'b1111, 32'h0000_0080, 32'h1122_3344, 2, 1'b0);
        vecs[9]  = mk(1'b0, 1'b1, 2'd3, 32'h0000_0050, 32'h0102_0304, 0, 32'h0,         1'b1, 4'b1111, 32'h0000_0050, 32'h0102_0304, 2, 1'b0);
        vecs[10] = mk(1'b0, 1'b0, 2'd1, 32'h0000_0062, 32'h0,         0, 32'hDEAD_BEEF, 1'b1, 4'b0100, 32'h0000_0060, 32'h0,         2, 1'b0);
        vecs[11] = mk(1'b0, 1'b1, 2'd2, 32'h0000_0041, 32'h0000_7777, 0, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0,         1, 1'b1);
        vecs[12] = mk(1'b1, 1'b0, 2'd0, 32'h0000_0200, 32'h0,         0, 32'h0BAD_C0DE, 1'b1, 4'b1111, 32'h0000_0200, 32'h0,         2, 1'b0);

        #2;
        check_outputs_zero();
        chk("rst_cpu_stall", 32'(bus.cpu_stall), 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Tie twice back-to-back with both requests held, starting from a fresh reset.
        do_reset();
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_be_op = 2'd0;
        bus.cpu_addr = 32'h0000_0100; bus.cpu_wdata = 32'h1111_1111;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h0000_0200; bus.dma_wdata = 32'h2222_2222;
        serve_one(a1, c1, ok1);
        serve_one(a2, c2, ok2);
        bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
        chk("tie1_done", 32'(ok1), 32'h1);
        chk("tie1_addr", a1, 32'h0000_0100);
        chk("tie1_cpu_won", 32'(c1), 32'h1);
        chk("tie2_done", 32'(ok2), 32'h1);
`ifdef MEM_ARB_RR_EN
        chk("tie2_addr", a2, 32'h0000_0200);
        chk("tie2_cpu_won", 32'(c2), 32'h0);
`else
        chk("tie2_addr", a2, 32'h0000_0100);
        chk("tie2_cpu_won", 32'(c2), 32'h1);
`endif
        @(posedge clk); #1;

        // Reset asserted while a CPU load is waiting on memory.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_be_op = 2'd0; bus.cpu_addr = 32'h0000_0300;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.mem_en;
        end
        chk("midrst_acc_reached", 32'(seen), 32'h1);
        reset = 1'b0;
        #1;
        chk("midrst_mem_en", 32'(bus.mem_en), 32'h0);
        chk("midrst_cpu_ack", 32'(bus.cpu_ack), 32'h0);
        bus.cpu_req = 1'b0;
        model_cpu_rdata = 32'h0; model_dma_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("postrst_no_ack", 32'(bus.cpu_ack), 32'h0);
            chk("postrst_no_en", 32'(bus.mem_en), 32'h0);
        end
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
